// File: rtl/nibble_frame_tx.sv
// Serial transmitter: snapshots three nibbles on start and sends each as start, 4 data LSB-first, even parity, stop.
// All outputs registered; tx is idle high and a new frame may start in the done cycle.
module nibble_frame_tx #(
   parameter int BIT_TICKS = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] word0,
   input  logic [3:0] word1,
   input  logic [3:0] word2,
   output logic       tx,
   output logic       busy,
   output logic       done,
   output logic [1:0] word_idx
);

   localparam int TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   tick_q, tick_d;
   logic [1:0]      bit_q, bit_d;
   logic [1:0]      idx_q, idx_d;
   logic [3:0]      snap0_q, snap1_q, snap2_q;
   logic [3:0]      snap0_d, snap1_d, snap2_d;
   logic            tx_q, tx_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [3:0]      cur_word;
   logic [1:0]      nxt_bit;
   logic            bit_end;

   always_comb begin
      case (idx_q)
         2'd0:    cur_word = snap0_q;
         2'd1:    cur_word = snap1_q;
         default: cur_word = snap2_q;
      endcase
   end

   assign nxt_bit = bit_q + 2'd1;
   assign bit_end = (tick_q == TICK_LAST);

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      idx_d   = idx_q;
      snap0_d = snap0_q;
      snap1_d = snap1_q;
      snap2_d = snap2_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      if (state_q == IDLE) begin
         tx_d   = 1'b1;
         busy_d = 1'b0;
         if (start) begin
            snap0_d = word0;
            snap1_d = word1;
            snap2_d = word2;
            state_d = START;
            tick_d  = '0;
            bit_d   = 2'd0;
            idx_d   = 2'd0;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
         end
      end else if (!bit_end) begin
         tick_d = tick_q + 1'b1;
      end else begin
         // Bit boundary: load the next bit value so it appears exactly as this one ends.
         tick_d = '0;
         case (state_q)
            START: begin
               state_d = DATA;
               bit_d   = 2'd0;
               tx_d    = cur_word[0];
            end
            DATA: begin
               if (bit_q == 2'd3) begin
                  state_d = PARITY;
                  tx_d    = ^cur_word;
               end else begin
                  bit_d = nxt_bit;
                  tx_d  = cur_word[nxt_bit];
               end
            end
            PARITY: begin
               state_d = STOP;
               tx_d    = 1'b1;
            end
            STOP: begin
               if (idx_q < 2'd2) begin
                  idx_d   = idx_q + 2'd1;
                  state_d = START;
                  tx_d    = 1'b0;
               end else begin
                  idx_d   = 2'd0;
                  state_d = IDLE;
                  tx_d    = 1'b1;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               tx_d    = 1'b1;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         tick_q  <= '0;
         bit_q   <= 2'd0;
         idx_q   <= 2'd0;
         snap0_q <= 4'd0;
         snap1_q <= 4'd0;
         snap2_q <= 4'd0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         idx_q   <= idx_d;
         snap0_q <= snap0_d;
         snap1_q <= snap1_d;
         snap2_q <= snap2_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign tx       = tx_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign word_idx = idx_q;

endmodule
